// File: rtl/neureka_dispatch_pkg.sv
// Shared types and defaults for the multi-engine NEUREKA job dispatcher.
package neureka_dispatch_pkg;

  localparam int NEUREKA_N_ENGINES      = 2;
  localparam int NEUREKA_DISPATCH_DEPTH = 2;
  localparam int NEUREKA_CORE_W         = 3;
  localparam int NEUREKA_CFG_W          = 8;
  localparam int NEUREKA_ID_W           = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_RUN   = 2'd2
  } dispatch_state_e;

  typedef struct packed {
    logic [NEUREKA_CORE_W-1:0] core;
    logic [NEUREKA_CFG_W-1:0]  cfg;
    logic [NEUREKA_ID_W-1:0]   id;
  } dispatch_job_t;

  // Round-robin candidate index: (base + off) mod n, with base < n and off < n.
  function automatic int rr_wrap(input int base, input int off, input int n);
    int s;
    s = base + off;
    return (s >= n) ? s - n : s;
  endfunction

endpackage

// File: rtl/neureka_dispatch_if.sv
// Job submission channel between the register file (master) and the dispatcher (slave).
interface neureka_dispatch_if #(
  parameter int N_CORES = 8,
  parameter int CFG_W   = 8,
  parameter int ID      = 8
);
  localparam int CORE_W = (N_CORES > 1) ? $clog2(N_CORES) : 1;

  logic              valid;
  logic              ready;
  logic [CORE_W-1:0] core;
  logic [CFG_W-1:0]  cfg;
  logic [ID-1:0]     id;

  modport master (output valid, core, cfg, input ready, id);
  modport slave  (input valid, core, cfg, output ready, id);
endinterface

// File: rtl/neureka_dispatch_fifo.sv
// Circular FIFO of arbitrary element type with full/empty flags and synchronous clear.
module neureka_dispatch_fifo #(
  parameter int  DEPTH = 2,
  parameter type T     = logic [7:0]
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic push_i,
  input  T     data_i,
  input  logic pop_i,
  output T     data_o,
  output logic full_o,
  output logic empty_o
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  T                 mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q, rd_q;
  logic [CNT_W-1:0] cnt_q;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_q];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (clear_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= ptr_inc(wr_q);
      if (do_pop)  rd_q <= ptr_inc(rd_q);
      if (do_push && !do_pop)      cnt_q <= cnt_q + CNT_W'(1);
      else if (!do_push && do_pop) cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  // Storage carries no reset; only entries between rd and wr are ever observed.
  always_ff @(posedge clk_i) begin
    if (do_push && !clear_i) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/neureka_dispatch.sv
// Multi-engine job dispatcher: queue, round-robin engine launch, per-core completion events.
// Define NEUREKA_DISPATCH_PERF_EN to build the per-engine saturating busy-cycle counters.
module neureka_dispatch
  import neureka_dispatch_pkg::*;
#(
  parameter int N_CORES   = 8,
  parameter int N_ENGINES = NEUREKA_N_ENGINES,
  parameter int N_CONTEXT = NEUREKA_DISPATCH_DEPTH,
  parameter int CFG_W     = 8,
  parameter int ID        = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      clear_i,
  neureka_dispatch_if.slave         job,
  output logic [N_ENGINES-1:0]      eng_start_o,
  output logic [N_ENGINES*CFG_W-1:0] eng_cfg_o,
  output logic [N_ENGINES*ID-1:0]   eng_id_o,
  input  logic [N_ENGINES-1:0]      eng_busy_i,
  input  logic [N_ENGINES-1:0]      eng_done_i,
  output logic [N_CORES-1:0]        evt_o,
  output logic                      busy_o,
  output logic [N_ENGINES*32-1:0]   perf_busy_cnt_o
);
  localparam int CORE_W = (N_CORES > 1) ? $clog2(N_CORES) : 1;
  localparam int RR_W   = (N_ENGINES > 1) ? $clog2(N_ENGINES) : 1;
  localparam int PND_W  = $clog2(N_ENGINES + 1);

  typedef struct packed {
    logic [CORE_W-1:0] core;
    logic [CFG_W-1:0]  cfg;
    logic [ID-1:0]     id;
  } job_t;
  typedef logic [PND_W:0] sum_t;

  job_t             push_job, head_job;
  logic             fifo_full, fifo_empty, push, dispatch, sel_vld;
  logic [ID-1:0]    id_q, id_d;
  logic [RR_W-1:0]  rr_q, rr_d, sel, idx;
  dispatch_state_e  state_q [N_ENGINES];
  dispatch_state_e  state_d [N_ENGINES];
  job_t             slot_q  [N_ENGINES];
  logic [PND_W-1:0] pend_q  [N_CORES];
  logic [PND_W-1:0] pend_d  [N_CORES];
  logic [N_CORES-1:0] evt_q, evt_d;
  sum_t             arr, sum;

  assign job.ready = !fifo_full && !clear_i;
  assign job.id    = id_q;
  assign push      = job.valid && job.ready;
  assign push_job  = '{core: job.core, cfg: job.cfg, id: id_q};

  neureka_dispatch_fifo #(
    .DEPTH (N_CONTEXT),
    .T     (job_t)
  ) i_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (clear_i),
    .push_i  (push),
    .data_i  (push_job),
    .pop_i   (dispatch),
    .data_o  (head_job),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // First idle, non-busy engine at or after the round-robin pointer.
  always_comb begin
    sel_vld = 1'b0;
    sel     = '0;
    idx     = '0;
    for (int i = 0; i < N_ENGINES; i++) begin
      idx = RR_W'(rr_wrap(int'(rr_q), i, N_ENGINES));
      if (!sel_vld && state_q[idx] == ST_IDLE && !eng_busy_i[idx]) begin
        sel_vld = 1'b1;
        sel     = idx;
      end
    end
  end

  assign dispatch = sel_vld && !fifo_empty && !clear_i;

  always_comb begin
    id_d = id_q;
    rr_d = rr_q;
    if (clear_i) begin
      id_d = '0;
      rr_d = '0;
    end else begin
      if (push) id_d = id_q + ID'(1);
      if (dispatch) rr_d = (sel == RR_W'(N_ENGINES - 1)) ? '0 : sel + RR_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      id_q <= '0;
      rr_q <= '0;
      for (int e = 0; e < N_ENGINES; e++) begin
        state_q[e] <= ST_IDLE;
        slot_q[e]  <= '0;
      end
    end else begin
      id_q <= id_d;
      rr_q <= rr_d;
      for (int e = 0; e < N_ENGINES; e++) state_q[e] <= state_d[e];
      if (dispatch) slot_q[sel] <= head_job;
    end
  end

  always_comb begin
    for (int e = 0; e < N_ENGINES; e++) begin
      state_d[e] = state_q[e];
      case (state_q[e])
        ST_IDLE:  if (dispatch && sel == RR_W'(e)) state_d[e] = ST_START;
        ST_START: state_d[e] = ST_RUN;
        ST_RUN:   if (eng_done_i[e]) state_d[e] = ST_IDLE;
        default:  state_d[e] = ST_IDLE;
      endcase
      if (clear_i) state_d[e] = ST_IDLE;
    end
  end

  always_comb begin
    busy_o = !fifo_empty || (|evt_q);
    for (int e = 0; e < N_ENGINES; e++) begin
      eng_start_o[e]              = (state_q[e] == ST_START);
      eng_cfg_o[e*CFG_W +: CFG_W] = slot_q[e].cfg;
      eng_id_o[e*ID +: ID]        = slot_q[e].id;
      if (state_q[e] != ST_IDLE) busy_o = 1'b1;
    end
    for (int c = 0; c < N_CORES; c++) begin
      if (pend_q[c] != '0) busy_o = 1'b1;
    end
  end

  // Completions for one core are serialised into back-to-back single-cycle events.
  always_comb begin
    arr = '0;
    sum = '0;
    for (int c = 0; c < N_CORES; c++) begin
      arr = '0;
      for (int e = 0; e < N_ENGINES; e++) begin
        if (state_q[e] == ST_RUN && eng_done_i[e] && slot_q[e].core == CORE_W'(c))
          arr = arr + sum_t'(1);
      end
      sum       = sum_t'(pend_q[c]) + arr;
      evt_d[c]  = (sum != '0);
      pend_d[c] = PND_W'(sum - sum_t'(evt_d[c]));
      if (clear_i) begin
        evt_d[c]  = 1'b0;
        pend_d[c] = '0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      evt_q <= '0;
      for (int c = 0; c < N_CORES; c++) pend_q[c] <= '0;
    end else begin
      evt_q <= evt_d;
      for (int c = 0; c < N_CORES; c++) pend_q[c] <= pend_d[c];
    end
  end

  assign evt_o = evt_q;

`ifdef NEUREKA_DISPATCH_PERF_EN
  logic [31:0] perf_q [N_ENGINES];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int e = 0; e < N_ENGINES; e++) perf_q[e] <= '0;
    end else begin
      for (int e = 0; e < N_ENGINES; e++) begin
        if (clear_i) perf_q[e] <= '0;
        else if (state_q[e] != ST_IDLE && perf_q[e] != 32'hFFFF_FFFF)
          perf_q[e] <= perf_q[e] + 32'd1;
      end
    end
  end

  always_comb begin
    for (int e = 0; e < N_ENGINES; e++) perf_busy_cnt_o[e*32 +: 32] = perf_q[e];
  end
`else
  assign perf_busy_cnt_o = '0;
`endif

endmodule

// File: tb/tb_neureka_dispatch.sv
// Bench for neureka_dispatch: reset, directed vector table, hand sequences, random vs. queue model.
`timescale 1ns/1ps
module tb_neureka_dispatch;
  localparam int NC = 8;
  localparam int NE = 2;
  localparam int NQ = 2;
  localparam int CW = 8;
  localparam int IW = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              clear = 1'b0;
  logic [NE-1:0]     eng_start, eng_busy, eng_done;
  logic [NE*CW-1:0]  eng_cfg;
  logic [NE*IW-1:0]  eng_id;
  logic [NC-1:0]     evt;
  logic              busy;
  logic [NE*32-1:0]  perf;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  neureka_dispatch_if #(.N_CORES(NC), .CFG_W(CW), .ID(IW)) jif ();

  neureka_dispatch #(
    .N_CORES(NC), .N_ENGINES(NE), .N_CONTEXT(NQ), .CFG_W(CW), .ID(IW)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .clear_i         (clear),
    .job             (jif),
    .eng_start_o     (eng_start),
    .eng_cfg_o       (eng_cfg),
    .eng_id_o        (eng_id),
    .eng_busy_i      (eng_busy),
    .eng_done_i      (eng_done),
    .evt_o           (evt),
    .busy_o          (busy),
    .perf_busy_cnt_o (perf)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic       v;
    logic [2:0] core;
    logic [7:0] cfg;
    logic [1:0] done;
    logic       rdy;
    int         id;     // -1: not checked
    logic [1:0] st;
    logic [7:0] scfg;
    logic [7:0] evt;
    logic       bsy;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic v, input int core, input int cfg, input logic [1:0] done,
                     input logic rdy, input int id, input logic [1:0] st, input int scfg,
                     input logic [7:0] e, input logic bsy);
    vec_t r;
    r.v = v; r.core = 3'(core); r.cfg = 8'(cfg); r.done = done; r.rdy = rdy; r.id = id;
    r.st = st; r.scfg = 8'(scfg); r.evt = e; r.bsy = bsy;
    tbl.push_back(r);
  endtask

  // ---------------- behavioural model ----------------
  typedef struct { int core; int cfg; int id; } mjob_t;
  mjob_t       mq[$];
  int          mph  [NE];   // 0 idle, 1 start, 2 run
  int          mown [NE];
  int          mcfg [NE];
  int          mjid [NE];
  longint      mperf[NE];
  int          mpend[NC];
  logic [NC-1:0] mevt;
  int          mid, mrr;
  bit          wrap_seen;

  task automatic model_reset();
    mq.delete();
    for (int e = 0; e < NE; e++) begin mph[e] = 0; mperf[e] = 0; end
    for (int c = 0; c < NC; c++) mpend[c] = 0;
    mevt = '0; mid = 0; mrr = 0;
  endtask

  task automatic model_step();
    int    arr[NC];
    int    sel;
    bit    accept;
    mjob_t j;
    if (clear) begin model_reset(); return; end
    for (int c = 0; c < NC; c++) arr[c] = 0;
    for (int e = 0; e < NE; e++) if (mph[e] == 2 && eng_done[e]) arr[mown[e]]++;
    sel = -1;
    if (mq.size() > 0)
      for (int i = 0; i < NE; i++) begin
        int e = (mrr + i) % NE;
        if (sel < 0 && mph[e] == 0 && !eng_busy[e]) sel = e;
      end
    accept = jif.valid && (mq.size() < NQ);
    for (int e = 0; e < NE; e++) begin
      if (mph[e] != 0 && mperf[e] < 64'hFFFF_FFFF) mperf[e]++;
      if (mph[e] == 1) mph[e] = 2;
      else if (mph[e] == 2 && eng_done[e]) mph[e] = 0;
    end
    if (sel >= 0) begin
      j = mq.pop_front();
      mph[sel] = 1; mown[sel] = j.core; mcfg[sel] = j.cfg; mjid[sel] = j.id;
      mrr = (sel + 1) % NE;
    end
    for (int c = 0; c < NC; c++) begin
      mpend[c] += arr[c];
      mevt[c] = (mpend[c] > 0);
      if (mevt[c]) mpend[c]--;
    end
    if (accept) begin
      mq.push_back('{core: int'(jif.core), cfg: int'(jif.cfg), id: mid});
      if (mid == 255) wrap_seen = 1'b1;
      mid = (mid + 1) % 256;
    end
  endtask

  task automatic model_check();
    logic [NE-1:0] st;
    logic          b;
    chk("m_ready", 64'(jif.ready), 64'((mq.size() < NQ) && !clear));
    if (jif.valid && jif.ready) chk("m_job_id", 64'(jif.id), 64'(mid));
    b = (mq.size() > 0) || (|mevt);
    for (int e = 0; e < NE; e++) begin
      st[e] = (mph[e] == 1);
      if (mph[e] != 0) begin
        b = 1'b1;
        chk($sformatf("m_cfg%0d", e), 64'(eng_cfg[e*CW +: CW]), 64'(mcfg[e]));
        chk($sformatf("m_id%0d", e), 64'(eng_id[e*IW +: IW]), 64'(mjid[e]));
      end
`ifdef NEUREKA_DISPATCH_PERF_EN
      chk($sformatf("m_perf%0d", e), 64'(perf[e*32 +: 32]), 64'(mperf[e]));
`else
      chk($sformatf("m_perf%0d", e), 64'(perf[e*32 +: 32]), 64'd0);
`endif
    end
    for (int c = 0; c < NC; c++) if (mpend[c] != 0) b = 1'b1;
    chk("m_start", 64'(eng_start), 64'(st));
    chk("m_evt", 64'(evt), 64'(mevt));
    chk("m_busy", 64'(busy), 64'(b));
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_clear();
    clear = 1'b1; jif.valid = 1'b1;
    @(negedge clk);
    chk("clear_blocks_ready", 64'(jif.ready), 64'd0);
    step();
    clear = 1'b0; jif.valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, nst;
    jif.valid = 1'b0; jif.core = '0; jif.cfg = '0;
    eng_busy = '0; eng_done = '0;
    wrap_seen = 1'b0;

    // reset values
    @(negedge clk);
    chk("rst_ready", 64'(jif.ready), 64'd1);
    chk("rst_id", 64'(jif.id), 64'd0);
    chk("rst_start", 64'(eng_start), 64'd0);
    chk("rst_cfg", 64'(eng_cfg), 64'd0);
    chk("rst_evt", 64'(evt), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_perf", 64'(perf), 64'd0);
    rst_n = 1'b1;
    step();

    // v core cfg done rdy id st scfg evt busy
    add(1,3,'h15,2'b00,1, 0,2'b00,0,   8'h00,0);
    add(0,0,0,   2'b00,1,-1,2'b00,0,   8'h00,1);
    add(0,0,0,   2'b00,1,-1,2'b01,'h15,8'h00,1);
    add(0,0,0,   2'b00,1,-1,2'b00,0,   8'h00,1);
    add(0,0,0,   2'b01,1,-1,2'b00,0,   8'h00,1);
    add(0,0,0,   2'b00,1,-1,2'b00,0,   8'h08,1);
    add(0,0,0,   2'b00,1,-1,2'b00,0,   8'h00,0);
    add(1,5,'h21,2'b00,1, 1,2'b00,0,   8'h00,0);
    add(1,5,'h22,2'b00,1, 2,2'b00,0,   8'h00,1);
    add(0,0,0,   2'b00,1,-1,2'b10,'h21,8'h00,1);
    add(0,0,0,   2'b00,1,-1,2'b01,'h22,8'h00,1);
    add(0,0,0,   2'b00,1,-1,2'b00,0,   8'h00,1);
    add(0,0,0,   2'b11,1,-1,2'b00,0,   8'h00,1);
    add(0,0,0,   2'b00,1,-1,2'b00,0,   8'h20,1);
    add(0,0,0,   2'b00,1,-1,2'b00,0,   8'h20,1);
    add(0,0,0,   2'b00,1,-1,2'b00,0,   8'h00,0);
    add(1,1,'h31,2'b00,1, 3,2'b00,0,   8'h00,0);
    add(1,6,'h36,2'b00,1, 4,2'b00,0,   8'h00,1);
    add(0,0,0,   2'b00,1,-1,2'b10,'h31,8'h00,1);
    add(0,0,0,   2'b00,1,-1,2'b01,'h36,8'h00,1);
    add(0,0,0,   2'b00,1,-1,2'b00,0,   8'h00,1);
    add(0,0,0,   2'b11,1,-1,2'b00,0,   8'h00,1);
    add(0,0,0,   2'b00,1,-1,2'b00,0,   8'h42,1);
    add(0,0,0,   2'b00,1,-1,2'b00,0,   8'h00,0);

    for (int k = 0; k < tbl.size(); k++) begin
      jif.valid = tbl[k].v; jif.core = tbl[k].core; jif.cfg = tbl[k].cfg;
      eng_done = tbl[k].done;
      @(negedge clk);
      chk($sformatf("t%0d_ready", k), 64'(jif.ready), 64'(tbl[k].rdy));
      if (tbl[k].id >= 0) chk($sformatf("t%0d_job_id", k), 64'(jif.id), 64'(tbl[k].id));
      chk($sformatf("t%0d_start", k), 64'(eng_start), 64'(tbl[k].st));
      if (tbl[k].st[0]) chk($sformatf("t%0d_cfg0", k), 64'(eng_cfg[7:0]), 64'(tbl[k].scfg));
      if (tbl[k].st[1]) chk($sformatf("t%0d_cfg1", k), 64'(eng_cfg[15:8]), 64'(tbl[k].scfg));
      chk($sformatf("t%0d_evt", k), 64'(evt), 64'(tbl[k].evt));
      chk($sformatf("t%0d_busy", k), 64'(busy), 64'(tbl[k].bsy));
      step();
    end
    jif.valid = 1'b0; eng_done = '0;

    // round-robin and back-pressure, engines never finish
    do_clear();
    acc = 0; nst = 0;
    jif.valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      jif.core = 3'(k); jif.cfg = 8'(8'h40 + k);
      @(negedge clk);
      if (jif.ready) begin
        chk($sformatf("rr_id%0d", acc), 64'(jif.id), 64'(acc));
        acc++;
      end
      if (eng_start != '0) begin
        chk($sformatf("rr_start%0d", nst), 64'(eng_start), (nst == 0) ? 64'd1 : 64'd2);
        chk($sformatf("rr_cfg%0d", nst), 64'(eng_cfg[nst*8 +: 8]), 64'(8'h40 + nst));
        nst++;
      end
      step();
    end
    jif.valid = 1'b0;
    chk("rr_accepted", 64'(acc), 64'd4);
    chk("rr_starts", 64'(nst), 64'd2);
    @(negedge clk);
    chk("rr_ready_low", 64'(jif.ready), 64'd0);
    chk("rr_busy", 64'(busy), 64'd1);
    step();

    // clear with engines running and queue full
    do_clear();
    @(negedge clk);
    chk("clr_busy", 64'(busy), 64'd0);
    chk("clr_start", 64'(eng_start), 64'd0);
    chk("clr_ready", 64'(jif.ready), 64'd1);
    chk("clr_next_id", 64'(jif.id), 64'd0);
    eng_done = 2'b11;
    step();
    eng_done = '0;
    @(negedge clk);
    chk("clr_no_evt", 64'(evt), 64'd0);
    chk("clr_no_busy", 64'(busy), 64'd0);
    step();

    // perf: START plus a 10-cycle RUN on engine 0
    jif.valid = 1'b1; jif.core = 3'd2; jif.cfg = 8'h5A;
    @(negedge clk);
    chk("perf_job_id", 64'(jif.id), 64'd0);
    step();
    jif.valid = 1'b0;
    step();
    @(negedge clk);
    chk("perf_start", 64'(eng_start), 64'd1);
    chk("perf_cfg", 64'(eng_cfg[7:0]), 64'h5A);
    step();
    repeat (9) @(posedge clk);
    #1;
    eng_done = 2'b01;
    step();
    eng_done = '0;
    @(negedge clk);
    chk("perf_evt", 64'(evt), 64'h04);
`ifdef NEUREKA_DISPATCH_PERF_EN
    chk("perf_cnt0", 64'(perf[31:0]), 64'd11);
`else
    chk("perf_cnt0", 64'(perf[31:0]), 64'd0);
`endif
    chk("perf_cnt1", 64'(perf[63:32]), 64'd0);
    step();
    @(negedge clk);
    chk("perf_busy_fall", 64'(busy), 64'd0);
    step();

    // randomized traffic against the model
    do_clear();
    model_reset();
    for (int cyc = 0; cyc < 2300; cyc++) begin
      clear     = (cyc >= 1500) && ($urandom_range(63) == 0);
      jif.valid = ($urandom_range(3) != 0);
      jif.core  = 3'($urandom);
      jif.cfg   = 8'($urandom);
      for (int e = 0; e < NE; e++) begin
        eng_busy[e] = ($urandom_range(7) == 0);
        eng_done[e] = ($urandom_range(3) == 0);
      end
      @(negedge clk);
      model_check();
      @(posedge clk);
      model_step();
      #1;
    end
    clear = 1'b0; jif.valid = 1'b0; eng_done = '0; eng_busy = '0;
    chk("id_wrap_reached", 64'(wrap_seen), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
